// File: rtl/led_pkg.sv
// Shared type codes, receiver state encodings and word-classification helper
// for the LED strip receiver.
package led_pkg;

  typedef enum logic [1:0] {
    TYPE_START = 2'd0,
    TYPE_LED   = 2'd1,
    TYPE_END   = 2'd2,
    TYPE_ERROR = 2'd3
  } led_type_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_EMIT  = 2'd2
  } rx_state_t;

  localparam logic [2:0] INIT_MARKER = 3'b111;
  localparam int         WORD_BITS   = 32;
  localparam int         INDEX_BITS  = 10;

  // First match wins: an all-ones LED frame is indistinguishable from END.
  function automatic led_type_t classify(input logic [WORD_BITS-1:0] word);
    if (word == '0)
      return TYPE_START;
    else if (word == '1)
      return TYPE_END;
    else if (word[31:29] == INIT_MARKER)
      return TYPE_LED;
    else
      return TYPE_ERROR;
  endfunction

endpackage

// File: rtl/sck_sync.sv
// Two-flop synchronisers for the strip clock and data, plus the sck
// rising-edge detect.
module sck_sync (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  output logic sck_edge,
  output logic mosi_sync
);

  logic sck_s1;
  logic sck_s2;
  logic sck_dly;
  logic mosi_s1;
  logic mosi_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_dly <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_dly <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // mosi and sck share the same synchroniser depth, so mosi_sync is aligned
  // with the edge pulse.
  assign sck_edge  = sck_s2 & ~sck_dly;
  assign mosi_sync = mosi_s2;

endmodule

// File: rtl/ledrx.sv
// LED strip word receiver: deserialises 32-bit frames from sck/mosi,
// classifies them and tracks the LED position since the last START.
module ledrx
  import led_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       ledrx_clk,
  input  logic       ledrx_reset,
  input  logic       mosi,
  input  logic       sck,
  output logic [7:0] blue_output,
  output logic [7:0] green_output,
  output logic [7:0] red_output,
  output logic [4:0] brightness_output,
  output logic [1:0] type_output,
  output logic [9:0] led_index,
  output logic       ledrx_valid,
  output logic       framing_error,
  output logic [1:0] debug_state
);

  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic                  sck_edge;
  logic                  mosi_sync;
  rx_state_t             state;
  logic [WORD_BITS-1:0]  shift_reg;
  logic [5:0]            bit_cnt;
  logic [IW-1:0]         idle_cnt;
  logic [INDEX_BITS-1:0] led_count;
  led_type_t             word_type;

  sck_sync u_sck_sync (
    .clk       (ledrx_clk),
    .reset     (ledrx_reset),
    .sck       (sck),
    .mosi      (mosi),
    .sck_edge  (sck_edge),
    .mosi_sync (mosi_sync)
  );

  assign word_type   = classify(shift_reg);
  assign debug_state = state;

  // Handshake: ledrx_valid is a one-cycle pulse with no back-pressure; every
  // data output is loaded on the same edge that raises it and then holds.
  always_ff @(posedge ledrx_clk) begin
    if (ledrx_reset) begin
      state             <= RX_IDLE;
      shift_reg         <= '0;
      bit_cnt           <= '0;
      idle_cnt          <= '0;
      led_count         <= '0;
      blue_output       <= '0;
      green_output      <= '0;
      red_output        <= '0;
      brightness_output <= '0;
      type_output       <= '0;
      led_index         <= '0;
      ledrx_valid       <= 1'b0;
      framing_error     <= 1'b0;
    end else begin
      ledrx_valid   <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (sck_edge) begin
            shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync};
            bit_cnt   <= 6'd1;
            idle_cnt  <= '0;
            state     <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (bit_cnt == 6'd32) begin
            // Load outputs now so they are valid during the RX_EMIT cycle.
            ledrx_valid       <= 1'b1;
            blue_output       <= shift_reg[23:16];
            green_output      <= shift_reg[15:8];
            red_output        <= shift_reg[7:0];
            brightness_output <= shift_reg[28:24];
            type_output       <= word_type;
            led_index         <= led_count;
            if (word_type == TYPE_START)
              led_count <= '0;
            else if (word_type == TYPE_LED && led_count != '1)
              led_count <= led_count + 1'b1;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            state    <= RX_EMIT;
          end else if (sck_edge) begin
            shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync};
            bit_cnt   <= bit_cnt + 6'd1;
            idle_cnt  <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            framing_error <= 1'b1;
            bit_cnt       <= '0;
            idle_cnt      <= '0;
            state         <= RX_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        RX_EMIT: begin
          if (sck_edge) begin
            shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync};
            bit_cnt   <= 6'd1;
            idle_cnt  <= '0;
            state     <= RX_SHIFT;
          end else begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ledrx.sv
// Self-checking bench for ledrx: drives strip frames, predicts each decoded
// word into a queue and compares on every ledrx_valid pulse.
module tb_ledrx;

  localparam int W = 41;

  logic       clk = 1'b0;
  logic       ledrx_reset = 1'b1;
  logic       mosi = 1'b0;
  logic       sck = 1'b0;
  logic [7:0] blue_output;
  logic [7:0] green_output;
  logic [7:0] red_output;
  logic [4:0] brightness_output;
  logic [1:0] type_output;
  logic [9:0] led_index;
  logic       ledrx_valid;
  logic       framing_error;
  logic [1:0] debug_state;

  logic [W-1:0] exp_q[$];
  int           n_compared = 0;
  int           n_mismatched = 0;
  int           valid_cnt = 0;
  int           fe_cnt = 0;
  int           model_count = 0;

  ledrx #(.IDLE_TIMEOUT(64)) dut (
    .ledrx_clk         (clk),
    .ledrx_reset       (ledrx_reset),
    .mosi              (mosi),
    .sck               (sck),
    .blue_output       (blue_output),
    .green_output      (green_output),
    .red_output        (red_output),
    .brightness_output (brightness_output),
    .type_output       (type_output),
    .led_index         (led_index),
    .ledrx_valid       (ledrx_valid),
    .framing_error     (framing_error),
    .debug_state       (debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    ledrx_reset = 1'b1;
    repeat (cycles) @(negedge clk);
    ledrx_reset = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: classify the word and track the LED count
  task automatic push_expect(input logic [31:0] w);
    logic [1:0] t;
    logic [9:0] idx;
    if (w == 32'h0)                 t = 2'd0;
    else if (w == 32'hFFFF_FFFF)    t = 2'd2;
    else if (w[31:29] == 3'b111)    t = 2'd1;
    else                            t = 2'd3;
    idx = 10'(model_count);
    if (t == 2'd0) model_count = 0;
    else if (t == 2'd1 && model_count < 1023) model_count++;
    exp_q.push_back({t, w[28:24], w[23:16], w[15:8], w[7:0], idx});
  endtask

  // driver: n bits MSB first, 8 clk low then 8 clk high per bit
  task automatic send_bits(input logic [31:0] w, input int n, input bit full);
    int seen;
    for (int i = 0; i < n; i++) begin
      sck  = 1'b0;
      mosi = w[31-i];
      repeat (8) @(negedge clk);
      sck = 1'b1;
      if (full && i == n - 1) begin
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          if (ledrx_valid && seen == 0) seen = k;
        end
        check_eq("latency", 32'(seen), 32'd4);
      end else begin
        repeat (8) @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    push_expect(w);
    send_bits(w, 32, 1'b1);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (framing_error) fe_cnt++;
    if (ledrx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("type",       32'(type_output),       32'(e[40:39]));
        check_eq("brightness", 32'(brightness_output), 32'(e[38:34]));
        check_eq("blue",       32'(blue_output),       32'(e[33:26]));
        check_eq("green",      32'(green_output),      32'(e[25:18]));
        check_eq("red",        32'(red_output),        32'(e[17:10]));
        check_eq("led_index",  32'(led_index),         32'(e[9:0]));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rgb"}, {8'h0, blue_output, green_output, red_output}, 32'h0);
    check_eq({tag, "_misc"}, {15'h0, brightness_output, type_output, led_index}, 32'h0);
    check_eq({tag, "_pulses"}, {30'h0, ledrx_valid, framing_error}, 32'h0);
  endtask

  initial begin
    int v0;
    int f0;
    logic [31:0] w;

    do_reset(4);
    @(negedge clk);
    check_outputs_zero("reset");
    check_eq("reset_state", 32'(debug_state), 32'd0);

    send_word(32'h0000_0000);
    send_word(32'hE510_2030);
    send_word(32'hFF01_0203);
    send_word(32'hFFFF_FFFF);
    send_word(32'h4011_2233);

    // partial word followed by a long sck stall
    v0 = valid_cnt;
    f0 = fe_cnt;
    send_bits(32'hE1AA_BBCC, 12, 1'b0);
    sck = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("timeout_fe", 32'(fe_cnt - f0), 32'd1);
    check_eq("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_eq("timeout_hold_red", 32'(red_output), 32'h33);
    check_eq("timeout_state", 32'(debug_state), 32'd0);
    send_word(32'h0000_0000);

    send_word(32'hE1AA_BBCC);

    // reset in the middle of an LED word
    v0 = valid_cnt;
    f0 = fe_cnt;
    send_bits(32'hE2DD_EEFF, 20, 1'b0);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    do_reset(2);
    model_count = 0;
    check_outputs_zero("midreset");
    repeat (4) @(negedge clk);
    check_eq("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_eq("midreset_no_fe", 32'(fe_cnt - f0), 32'd0);
    send_word(32'hE301_0203);

    // random mix of LED and arbitrary words
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:29] = 3'b111;
      send_word(w);
    end

    repeat (20) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("fe_total", 32'(fe_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
